// File: rtl/pkt_rx_reader.sv
// pkt_rx_reader: XGE MAC receive reader with credit-based read enable, skid FIFO and per-packet status.
// Define PKT_RX_READER_STATS_EN to enable the pkt_cnt/err_cnt/drop_cnt statistics counters.

module pkt_rx_reader #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_156m25,
    input  logic        reset_156m25,
    input  logic        pkt_rx_avail,
    output logic        pkt_rx_ren,
    input  logic [63:0] pkt_rx_data,
    input  logic        pkt_rx_val,
    input  logic        pkt_rx_sop,
    input  logic        pkt_rx_eop,
    input  logic [2:0]  pkt_rx_mod,
    input  logic        pkt_rx_err,
    output logic [63:0] out_data,
    output logic        out_val,
    output logic        out_sop,
    output logic        out_eop,
    output logic [2:0]  out_mod,
    input  logic        out_rdy,
    output logic        stat_val,
    output logic [15:0] stat_len,
    output logic        stat_err,
    output logic [31:0] pkt_cnt,
    output logic [31:0] err_cnt,
    output logic [31:0] drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_SOP, IN_PKT} state_t;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
    } word_t;

    state_t        state_q, state_d;
    logic          inflight_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    word_t         fifo_mem [FIFO_DEPTH];
    word_t         out_q, out_d;
    logic          out_val_q, out_val_d;
    logic [16:0]   len_q, len_d;
    logic          ferr_q, ferr_d;
    logic          stat_val_q, stat_val_d;
    logic          stat_err_q, stat_err_d;
    logic [15:0]   stat_len_q, stat_len_d;

    logic          ren;
    logic          in_pkt;
    logic          accept;
    logic          out_load;
    logic          pop;
    logic          bypass;
    logic          push_req;
    logic          overflow;
    logic          push;
    word_t         in_word;
    logic [16:0]   last_bytes;
    logic [16:0]   len_final;

    // The output register is the FIFO head; an incoming word bypasses storage when it is empty.
    always_comb begin
        ren = (state_q != IDLE)
              && ((int'(cnt_q) + int'(inflight_q)) <= (FIFO_DEPTH - 2))
              && !(pkt_rx_val && pkt_rx_eop);

        in_pkt       = (state_q == IN_PKT);
        accept       = pkt_rx_val && (in_pkt || pkt_rx_sop);
        in_word.data = pkt_rx_data;
        in_word.sop  = pkt_rx_sop && !in_pkt;
        in_word.eop  = pkt_rx_eop;
        in_word.mod  = pkt_rx_mod;

        out_load = !out_val_q || out_rdy;
        pop      = out_load && (cnt_q != '0);
        bypass   = out_load && (cnt_q == '0) && accept;
        push_req = accept && !bypass;
        overflow = push_req && (cnt_q == FULL_CNT) && !pop;
        push     = push_req && !overflow;

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        out_d     = out_q;
        out_val_d = out_val_q;
        if (out_load) begin
            if (pop) begin
                out_d     = fifo_mem[rd_ptr_q];
                out_val_d = 1'b1;
            end else if (bypass) begin
                out_d     = in_word;
                out_val_d = 1'b1;
            end else begin
                out_val_d = 1'b0;
            end
        end
    end

    // Framing FSM and length accounting; status never waits on the output stream.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        ferr_d     = ferr_q;
        stat_val_d = 1'b0;
        stat_len_d = stat_len_q;
        stat_err_d = stat_err_q;
        last_bytes = (pkt_rx_mod == 3'd0) ? 17'd8 : {14'd0, pkt_rx_mod};
        len_final  = len_q + last_bytes;

        case (state_q)
            IDLE, WAIT_SOP: begin
                if (pkt_rx_val && pkt_rx_sop) begin
                    ferr_d = 1'b0;
                    if (pkt_rx_eop) begin
                        stat_val_d = 1'b1;
                        stat_len_d = last_bytes[15:0];
                        stat_err_d = pkt_rx_err;
                        state_d    = IDLE;
                    end else begin
                        len_d   = 17'd8;
                        state_d = IN_PKT;
                    end
                end else if ((state_q == IDLE) && pkt_rx_avail) begin
                    state_d = WAIT_SOP;
                end
            end
            IN_PKT: begin
                if (pkt_rx_val) begin
                    if (pkt_rx_eop) begin
                        stat_val_d = 1'b1;
                        stat_len_d = len_final[16] ? 16'hFFFF : len_final[15:0];
                        stat_err_d = pkt_rx_err || ferr_q || pkt_rx_sop;
                        state_d    = IDLE;
                    end else begin
                        len_d = len_q[16] ? len_q : len_q + 17'd8;
                        if (pkt_rx_sop) begin
                            ferr_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_q      <= '0;
            out_val_q  <= 1'b0;
            len_q      <= '0;
            ferr_q     <= 1'b0;
            stat_val_q <= 1'b0;
            stat_len_q <= '0;
            stat_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= ren;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_q      <= out_d;
            out_val_q  <= out_val_d;
            len_q      <= len_d;
            ferr_q     <= ferr_d;
            stat_val_q <= stat_val_d;
            stat_len_q <= stat_len_d;
            stat_err_q <= stat_err_d;
        end
    end

    always_ff @(posedge clk_156m25) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= in_word;
        end
    end

    // The credit rule leaves headroom for the in-flight read, so a full FIFO never sees data.
    overflow_never: assert property (@(posedge clk_156m25) disable iff (reset_156m25) !overflow);

`ifdef PKT_RX_READER_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;
    logic        drop_word;

    always_comb begin
        drop_word  = (pkt_rx_val && !in_pkt && !pkt_rx_sop) || overflow;
        pkt_cnt_d  = pkt_cnt_q + {31'd0, stat_val_d};
        err_cnt_d  = err_cnt_q + {31'd0, stat_val_d && stat_err_d};
        drop_cnt_d = drop_cnt_q + {31'd0, drop_word};
    end

    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign err_cnt  = err_cnt_q;
    assign drop_cnt = drop_cnt_q;
`else
    assign pkt_cnt  = '0;
    assign err_cnt  = '0;
    assign drop_cnt = '0;
`endif

    assign pkt_rx_ren = ren;
    assign out_data   = out_q.data;
    assign out_sop    = out_q.sop;
    assign out_eop    = out_q.eop;
    assign out_mod    = out_q.mod;
    assign out_val    = out_val_q;
    assign stat_val   = stat_val_q;
    assign stat_len   = stat_len_q;
    assign stat_err   = stat_err_q;

endmodule

// File: tb/tb_pkt_rx_reader.sv
// Testbench for pkt_rx_reader: behavioural MAC model, stream/status monitors and a table of packets
// plus hand-written back-pressure, drop and mid-packet reset sequences.

module tb_pkt_rx_reader;

    localparam int DEPTH = 4;
`ifdef PKT_RX_READER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        pkt_rx_avail;
    logic        pkt_rx_ren;
    logic [63:0] pkt_rx_data;
    logic        pkt_rx_val;
    logic        pkt_rx_sop;
    logic        pkt_rx_eop;
    logic [2:0]  pkt_rx_mod;
    logic        pkt_rx_err;
    logic [63:0] out_data;
    logic        out_val;
    logic        out_sop;
    logic        out_eop;
    logic [2:0]  out_mod;
    logic        out_rdy;
    logic        stat_val;
    logic [15:0] stat_len;
    logic        stat_err;
    logic [31:0] pkt_cnt;
    logic [31:0] err_cnt;
    logic [31:0] drop_cnt;

    pkt_rx_reader #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_156m25  (clk),
        .reset_156m25(reset),
        .pkt_rx_avail(pkt_rx_avail),
        .pkt_rx_ren  (pkt_rx_ren),
        .pkt_rx_data (pkt_rx_data),
        .pkt_rx_val  (pkt_rx_val),
        .pkt_rx_sop  (pkt_rx_sop),
        .pkt_rx_eop  (pkt_rx_eop),
        .pkt_rx_mod  (pkt_rx_mod),
        .pkt_rx_err  (pkt_rx_err),
        .out_data    (out_data),
        .out_val     (out_val),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_mod     (out_mod),
        .out_rdy     (out_rdy),
        .stat_val    (stat_val),
        .stat_len    (stat_len),
        .stat_err    (stat_err),
        .pkt_cnt     (pkt_cnt),
        .err_cnt     (err_cnt),
        .drop_cnt    (drop_cnt)
    );

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic        err;
    } mac_word_t;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        int          cyc;
    } obs_word_t;

    typedef struct {
        logic [15:0] len;
        logic        err;
        int          cyc;
    } obs_stat_t;

    typedef struct {
        int          nwords;
        logic [2:0]  mod;
        logic        err;
        int          spur;
        logic [15:0] exp_len;
        logic        exp_err;
    } vec_t;

    mac_word_t mac_mem [0:255];
    int        mac_rd = 0;
    int        mac_len = 0;
    int        cyc = 0;
    int        last_eop_cyc = 0;
    int        checks = 0;
    int        errors = 0;
    logic      ren_smp;
    obs_word_t obs_q[$];
    obs_stat_t stat_q[$];
    vec_t      vecs [7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // MAC model: a read enable sampled in one cycle returns the next queued word in the following cycle.
    initial begin
        pkt_rx_avail = 1'b0;
        pkt_rx_val   = 1'b0;
        pkt_rx_data  = '0;
        pkt_rx_sop   = 1'b0;
        pkt_rx_eop   = 1'b0;
        pkt_rx_mod   = '0;
        pkt_rx_err   = 1'b0;
        forever begin
            @(negedge clk);
            ren_smp = pkt_rx_ren;
            @(posedge clk);
            #1;
            if (reset || !ren_smp || (mac_rd >= mac_len)) begin
                pkt_rx_val  = 1'b0;
                pkt_rx_data = '0;
                pkt_rx_sop  = 1'b0;
                pkt_rx_eop  = 1'b0;
                pkt_rx_mod  = '0;
                pkt_rx_err  = 1'b0;
            end else begin
                pkt_rx_val  = 1'b1;
                pkt_rx_data = mac_mem[mac_rd].data;
                pkt_rx_sop  = mac_mem[mac_rd].sop;
                pkt_rx_eop  = mac_mem[mac_rd].eop;
                pkt_rx_mod  = mac_mem[mac_rd].mod;
                pkt_rx_err  = mac_mem[mac_rd].err;
                if (mac_mem[mac_rd].eop) last_eop_cyc = cyc;
                mac_rd = mac_rd + 1;
            end
            pkt_rx_avail = (mac_rd < mac_len);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (out_val && out_rdy) obs_q.push_back('{out_data, out_sop, out_eop, out_mod, cyc});
            if (stat_val) stat_q.push_back('{stat_len, stat_err, cyc});
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushMacWord(input logic [63:0] d, input logic s, input logic e,
                               input logic [2:0] m, input logic r);
        mac_mem[mac_len] = '{d, s, e, m, r};
        mac_len = mac_len + 1;
    endtask

    task automatic applyStimulus(input int id, input int n, input logic [2:0] mod,
                                 input logic err, input int spur);
        for (int w = 0; w < n; w++) begin
            pushMacWord({32'(id), 32'(w)}, (w == 0) || (w == spur), (w == n - 1),
                        (w == n - 1) ? mod : 3'd0, (w == n - 1) ? err : 1'b0);
        end
    endtask

    task automatic clearObs();
        obs_q.delete();
        stat_q.delete();
    endtask

    task automatic waitStatus(input string name);
        int k = 0;
        while ((stat_q.size() == 0) && (k < 300)) begin
            @(posedge clk);
            k++;
        end
        if (stat_q.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL %s timeout: got no stat_val, expected one within 300 cycles", name);
        end
        repeat (6) @(posedge clk);
    endtask

    task automatic checkStatus(input string name, input logic [15:0] len, input logic err);
        checkOutput({name, " stat count"}, 64'(stat_q.size()), 64'd1);
        if (stat_q.size() > 0) begin
            checkOutput({name, " stat_len"}, 64'(stat_q[0].len), 64'(len));
            checkOutput({name, " stat_err"}, 64'(stat_q[0].err), 64'(err));
            checkOutput({name, " stat latency"}, 64'(stat_q[0].cyc - last_eop_cyc), 64'd1);
        end
    endtask

    task automatic checkPacket(input string name, input int id, input int n,
                               input logic [2:0] mod, input bit timing);
        checkOutput({name, " words"}, 64'(obs_q.size()), 64'(n));
        for (int i = 0; (i < n) && (i < obs_q.size()); i++) begin
            checkOutput($sformatf("%s w%0d data", name, i), obs_q[i].data, {32'(id), 32'(i)});
            checkOutput($sformatf("%s w%0d sop", name, i), 64'(obs_q[i].sop), 64'(i == 0));
            checkOutput($sformatf("%s w%0d eop", name, i), 64'(obs_q[i].eop), 64'(i == n - 1));
            checkOutput($sformatf("%s w%0d mod", name, i), 64'(obs_q[i].mod),
                        64'((i == n - 1) ? mod : 3'd0));
        end
        if (timing && (obs_q.size() == n) && (stat_q.size() > 0)) begin
            checkOutput({name, " back-to-back"}, 64'(obs_q[n-1].cyc - obs_q[0].cyc), 64'(n - 1));
            checkOutput({name, " eop with stat"}, 64'(obs_q[n-1].cyc), 64'(stat_q[0].cyc));
        end
    endtask

    task automatic checkCounters(input string name, input int p, input int e, input int d);
        checkOutput({name, " pkt_cnt"}, 64'(pkt_cnt), STATS ? 64'(p) : 64'd0);
        checkOutput({name, " err_cnt"}, 64'(err_cnt), STATS ? 64'(e) : 64'd0);
        checkOutput({name, " drop_cnt"}, 64'(drop_cnt), STATS ? 64'(d) : 64'd0);
    endtask

    initial begin
        int start;
        int k;

        vecs[0] = '{3, 3'd5, 1'b0, -1, 16'd21, 1'b0};
        vecs[1] = '{1, 3'd0, 1'b1, -1, 16'd8,  1'b1};
        vecs[2] = '{2, 3'd0, 1'b0, -1, 16'd16, 1'b0};
        vecs[3] = '{5, 3'd7, 1'b0, -1, 16'd39, 1'b0};
        vecs[4] = '{4, 3'd1, 1'b1, -1, 16'd25, 1'b1};
        vecs[5] = '{1, 3'd3, 1'b0, -1, 16'd3,  1'b0};
        vecs[6] = '{4, 3'd2, 1'b0,  1, 16'd26, 1'b1};

        reset   = 1'b1;
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset ren", 64'(pkt_rx_ren), 64'd0);
        checkOutput("reset out_val", 64'(out_val), 64'd0);
        checkOutput("reset out_data", out_data, 64'd0);
        checkOutput("reset out_sop", 64'(out_sop), 64'd0);
        checkOutput("reset out_eop", 64'(out_eop), 64'd0);
        checkOutput("reset out_mod", 64'(out_mod), 64'd0);
        checkOutput("reset stat_val", 64'(stat_val), 64'd0);
        checkOutput("reset stat_len", 64'(stat_len), 64'd0);
        checkOutput("reset stat_err", 64'(stat_err), 64'd0);
        checkCounters("reset", 0, 0, 0);

        for (int i = 0; i < 7; i++) begin
            clearObs();
            applyStimulus(100 + i, vecs[i].nwords, vecs[i].mod, vecs[i].err, vecs[i].spur);
            waitStatus($sformatf("vec%0d", i));
            checkStatus($sformatf("vec%0d", i), vecs[i].exp_len, vecs[i].exp_err);
            checkPacket($sformatf("vec%0d", i), 100 + i, vecs[i].nwords, vecs[i].mod, 1'b1);
        end
        checkCounters("table", 7, 3, 0);

        // Back-pressure: the reader must stop at DEPTH words and hold the head stable.
        clearObs();
        @(posedge clk);
        #1 out_rdy = 1'b0;
        start = mac_rd;
        applyStimulus(200, 10, 3'd4, 1'b0, -1);
        repeat (25) @(negedge clk);
        checkOutput("bp words read", 64'(mac_rd - start), 64'(DEPTH));
        checkOutput("bp ren stalled", 64'(pkt_rx_ren), 64'd0);
        checkOutput("bp out_val held", 64'(out_val), 64'd1);
        checkOutput("bp out_data held", out_data, {32'd200, 32'd0});
        checkOutput("bp out_sop held", 64'(out_sop), 64'd1);
        checkOutput("bp no early stat", 64'(stat_q.size()), 64'd0);
        @(posedge clk);
        #1 out_rdy = 1'b1;
        waitStatus("bp");
        checkStatus("bp", 16'd76, 1'b0);
        checkPacket("bp", 200, 10, 3'd4, 1'b0);
        checkCounters("bp", 8, 3, 0);

        clearObs();
        pushMacWord(64'hDEAD_0000_0000_0001, 1'b0, 1'b0, 3'd0, 1'b0);
        pushMacWord(64'hDEAD_0000_0000_0002, 1'b0, 1'b0, 3'd0, 1'b0);
        applyStimulus(300, 2, 3'd0, 1'b0, -1);
        waitStatus("drop");
        checkStatus("drop", 16'd16, 1'b0);
        checkPacket("drop", 300, 2, 3'd0, 1'b1);
        checkCounters("drop", 9, 3, 2);

        // Reset while a packet is partially read: outputs clear at once and no status escapes.
        clearObs();
        @(posedge clk);
        #1 out_rdy = 1'b0;
        start = mac_rd;
        applyStimulus(400, 5, 3'd1, 1'b0, -1);
        k = 0;
        while (((mac_rd - start) < 2) && (k < 100)) begin
            @(negedge clk);
            k++;
        end
        checkOutput("rst words before", 64'(mac_rd - start), 64'd2);
        checkOutput("rst out_val before", 64'(out_val), 64'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst ren", 64'(pkt_rx_ren), 64'd0);
        checkOutput("rst out_val", 64'(out_val), 64'd0);
        checkOutput("rst out_data", out_data, 64'd0);
        checkOutput("rst out_sop", 64'(out_sop), 64'd0);
        checkOutput("rst stat_val", 64'(stat_val), 64'd0);
        checkCounters("rst", 0, 0, 0);
        mac_len = mac_rd;
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b0;
        out_rdy = 1'b1;
        clearObs();
        repeat (8) @(posedge clk);
        checkOutput("rst no status", 64'(stat_q.size()), 64'd0);
        checkOutput("rst no stream", 64'(obs_q.size()), 64'd0);
        applyStimulus(500, 1, 3'd0, 1'b0, -1);
        waitStatus("post-rst");
        checkStatus("post-rst", 16'd8, 1'b0);
        checkPacket("post-rst", 500, 1, 3'd0, 1'b1);
        checkCounters("post-rst", 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors = errors + 1;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 1000000 time units");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
